// File: rtl/airi5c_alu_b_arbiter.sv
// Operand-B path arbiter: execute stage vs. one auxiliary requester.
// Pipeline has priority; a wait counter forces a slot to bound starvation.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef SRC_B_SEL_WIDTH
`define SRC_B_SEL_WIDTH 2
`endif
`ifndef SRC_B_RS2
`define SRC_B_RS2 2'd0
`endif
`ifndef SRC_B_IMM
`define SRC_B_IMM 2'd1
`endif
`ifndef SRC_B_FOUR
`define SRC_B_FOUR 2'd2
`endif
`ifndef SRC_B_ZERO
`define SRC_B_ZERO 2'd3
`endif

module airi5c_alu_b_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        pipe_req_i,
  input  logic [`SRC_B_SEL_WIDTH-1:0] pipe_src_b_sel_i,
  input  logic [`XPR_LEN-1:0]         pipe_imm_i,
  input  logic                        pipe_was_compressed_i,
  output logic                        pipe_stall_o,
  input  logic                        aux_req_i,
  input  logic [`XPR_LEN-1:0]         aux_op_b_i,
  output logic                        aux_gnt_o,
  output logic                        aux_rvalid_o,
  output logic [`XPR_LEN-1:0]         aux_result_o,
  input  logic [`XPR_LEN-1:0]         alu_out_i,
  output logic [`SRC_B_SEL_WIDTH-1:0] src_b_sel_o,
  output logic [`XPR_LEN-1:0]         imm_o,
  output logic                        was_compressed_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AUX   = 2'd1,
    FORCE = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(MAX_WAIT - 1);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       gnt;
  logic       both;

  assign both = aux_req_i & pipe_req_i;

  // Waiting cycles in AUX count too, so the bound holds across back-to-back use.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    gnt     = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt = aux_req_i & ~pipe_req_i;
        if (gnt) begin
          state_d = AUX;
          wait_d  = 4'd0;
        end else if (both && wait_q >= LAST) begin
          state_d = FORCE;
        end else if (both) begin
          wait_d = wait_q + 4'd1;
        end else begin
          wait_d = 4'd0;
        end
      end
      AUX: begin
        gnt = aux_req_i & ~pipe_req_i;
        if (gnt) begin
          wait_d = 4'd0;
        end else begin
          state_d = IDLE;
          wait_d  = both ? wait_q + 4'd1 : 4'd0;
        end
      end
      FORCE: begin
        gnt     = aux_req_i;
        state_d = AUX;
        wait_d  = 4'd0;
      end
      default: begin
        state_d = IDLE;
        wait_d  = 4'd0;
      end
    endcase
  end

  assign aux_gnt_o        = gnt;
  assign pipe_stall_o     = gnt & pipe_req_i;
  assign src_b_sel_o      = gnt ? `SRC_B_IMM : pipe_src_b_sel_i;
  assign imm_o            = gnt ? aux_op_b_i : pipe_imm_i;
  assign was_compressed_o = gnt ? 1'b0 : pipe_was_compressed_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aux_rvalid_o <= 1'b0;
      aux_result_o <= '0;
    end else begin
      aux_rvalid_o <= gnt;
      if (gnt) aux_result_o <= alu_out_i;
    end
  end

endmodule
